// File: rtl/uart_fifo_controller.sv
// Memory-mapped UART with TX/RX FIFOs, a runtime baud divisor and sticky error flags.
// Registers: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved (reads 0).
module uart_fifo_controller #(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  output logic        serial_out,
  input  logic [1:0]  address,
  input  logic        writeenable,
  input  logic [31:0] writedata,
  input  logic        readenable,
  output logic [31:0] readdata
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [DIV_W-1:0] One = DIV_W'(1);
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(4);
  localparam logic [FIFO_AW:0] PtrOne = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic data_wr, div_wr, data_rd, stat_rd;
  assign data_wr = writeenable && (address == 2'd0);
  assign div_wr  = writeenable && (address == 2'd2);
  assign data_rd = readenable && (address == 2'd0);
  assign stat_rd = readenable && (address == 2'd1);

  logic unused_wd_bits;
  assign unused_wd_bits = ^writedata[31:DIV_W];

  logic [DIV_W-1:0] div_q;
  always_ff @(posedge clk) begin
    if (reset) div_q <= DIV_W'(DEFAULT_DIV);
    else if (div_wr) div_q <= (writedata[DIV_W-1:0] < MinDiv) ? MinDiv : writedata[DIV_W-1:0];
  end

  // FIFOs: the extra pointer bit separates full from empty.
  logic [7:0]     tx_mem [Depth];
  logic [7:0]     rx_mem [Depth];
  logic [FIFO_AW:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_push_req;
  logic [7:0] tx_head, rx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                    (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                    (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
  assign tx_head  = tx_mem[tx_rd_q[FIFO_AW-1:0]];
  assign rx_head  = rx_mem[rx_rd_q[FIFO_AW-1:0]];

  assign tx_push = data_wr && (!tx_full || tx_pop);
  assign rx_pop  = data_rd && !rx_empty;
  assign rx_push = rx_push_req && (!rx_full || rx_pop);

  logic [7:0] rx_sh_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= writedata[7:0];
    if (rx_push) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PtrOne;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrOne;
      if (rx_push) rx_wr_q <= rx_wr_q + PtrOne;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrOne;
    end
  end

  // TX engine: divisor is latched per frame so in-flight frames keep their timing.
  state_e           tx_state_q;
  logic [DIV_W-1:0] tx_cnt_q, tx_div_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_sh_q;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - One);
  assign tx_pop = !tx_empty &&
                  ((tx_state_q == StIdle) || ((tx_state_q == StStop) && tx_bit_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(DEFAULT_DIV);
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      serial_out <= 1'b1;
    end else begin
      if (tx_pop) begin
        tx_state_q <= StStart;
        tx_sh_q    <= tx_head;
        tx_div_q   <= div_q;
        tx_cnt_q   <= '0;
        serial_out <= 1'b0;
      end else begin
        case (tx_state_q)
          StStart: begin
            if (tx_bit_end) begin
              tx_state_q <= StData;
              tx_cnt_q   <= '0;
              tx_bit_q   <= '0;
              serial_out <= tx_sh_q[0];
            end else tx_cnt_q <= tx_cnt_q + One;
          end
          StData: begin
            if (tx_bit_end) begin
              tx_cnt_q <= '0;
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= StStop;
                serial_out <= 1'b1;
              end else begin
                tx_bit_q   <= tx_bit_q + 3'd1;
                tx_sh_q    <= tx_sh_q >> 1;
                serial_out <= tx_sh_q[1];
              end
            end else tx_cnt_q <= tx_cnt_q + One;
          end
          StStop: begin
            if (tx_bit_end) tx_state_q <= StIdle;
            else tx_cnt_q <= tx_cnt_q + One;
          end
          default: ;
        endcase
      end
    end
  end

  // RX engine behind a 2-flop synchroniser; rx_prev_q gives the falling-edge detect.
  state_e           rx_state_q;
  logic [DIV_W-1:0] rx_cnt_q, rx_div_q;
  logic [2:0]       rx_bit_q;
  logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic             rx_bit_end, rx_stop_done, frame_evt;

  assign rx_bit_end   = (rx_cnt_q == rx_div_q - One);
  assign rx_stop_done = (rx_state_q == StStop) && rx_bit_end;
  assign rx_push_req  = rx_stop_done && rx_sync2_q;
  assign frame_evt    = rx_stop_done && !rx_sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(DEFAULT_DIV);
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_sync1_q <= serial_in;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      case (rx_state_q)
        StIdle: begin
          rx_div_q <= div_q;
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync2_q) rx_state_q <= StStart;
        end
        StStart: begin
          if (rx_cnt_q == (rx_div_q >> 1)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync2_q ? StIdle : StData;
          end else rx_cnt_q <= rx_cnt_q + One;
        end
        StData: begin
          if (rx_bit_end) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_sync2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= StStop;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else rx_cnt_q <= rx_cnt_q + One;
        end
        StStop: begin
          if (rx_bit_end) rx_state_q <= StIdle;
          else rx_cnt_q <= rx_cnt_q + One;
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  // Sticky flags: a STATUS read clears them unless a new event lands on the same cycle.
  logic rx_overrun_q, frame_err_q, tx_ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_ovf_q     <= 1'b0;
    end else begin
      rx_overrun_q <= (rx_overrun_q && !stat_rd) || (rx_push_req && !rx_push);
      frame_err_q  <= (frame_err_q && !stat_rd) || frame_evt;
      tx_ovf_q     <= (tx_ovf_q && !stat_rd) || (data_wr && !tx_push);
    end
  end

  logic [31:0] readdata_d;
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: begin
        readdata_d[8]   = !rx_empty;
        readdata_d[7:0] = rx_empty ? 8'd0 : rx_head;
      end
      2'd1: begin
        readdata_d[0]  = !rx_empty;
        readdata_d[1]  = rx_full;
        readdata_d[2]  = tx_full;
        readdata_d[3]  = tx_empty;
        readdata_d[4]  = (tx_state_q != StIdle);
        readdata_d[5]  = rx_overrun_q;
        readdata_d[6]  = frame_err_q;
        readdata_d[7]  = tx_ovf_q;
        readdata_d[16] = !tx_full;
      end
      2'd2: readdata_d[DIV_W-1:0] = div_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else if (readenable) readdata <= readdata_d;
  end

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller: bus register access, TX waveform, RX framing,
// FIFO full/overflow behaviour and reset mid-frame.
module tb_uart_fifo_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b1;
  logic        serial_out;
  logic [1:0]  address = 2'd0;
  logic        writeenable = 1'b0;
  logic [31:0] writedata = '0;
  logic        readenable = 1'b0;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic line_log [16384];

  uart_fifo_controller #(
    .FIFO_AW    (4),
    .DEFAULT_DIV(434),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .address    (address),
    .writeenable(writeenable),
    .writedata  (writedata),
    .readenable (readenable),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 16384) line_log[cyc] <= serial_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    writeenable = 1'b1;
    @(negedge clk);
    writeenable = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    readenable = 1'b1;
    @(negedge clk);
    readenable = 1'b0;
    d = readdata;
  endtask

  // Caller sits on a negedge; each bit is held for div clocks.
  task automatic send_rx(input logic [7:0] b, input int div, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      serial_in = frame[k];
      repeat (div) @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  // Compare logged TX line against nframes contiguous frames of (first + j), div=4.
  task automatic check_tx_line(input string tag, input int base, input int nframes,
                               input logic [7:0] first);
    int bad;
    logic [7:0] bv;
    logic expbit;
    bad = 0;
    for (int j = 0; j < nframes; j++) begin
      bv = first + 8'(j);
      for (int b = 0; b < 10; b++) begin
        if (b == 0) expbit = 1'b0;
        else if (b == 9) expbit = 1'b1;
        else expbit = bv[b-1];
        for (int c = 0; c < 4; c++)
          if (line_log[base + j * 40 + b * 4 + c] !== expbit) bad++;
      end
    end
    for (int c = 0; c < 2; c++)
      if (line_log[base + nframes * 40 + c] !== 1'b1) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int base;

    // Reset state
    do_reset();
    check("rst_serial_out", 64'(serial_out), 64'd1);
    check("rst_readdata", 64'(readdata), 64'd0);
    bus_read(2'd1, rd);
    check("rst_status", 64'(rd), 64'h10008);
    bus_read(2'd2, rd);
    check("rst_div", 64'(rd), 64'd434);

    // 1: single 0xA5 frame at DIV=4
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'hA5);
    base = cyc + 1;
    bus_read(2'd1, rd);
    check("t1_status_busy", 64'(rd), 64'h10018);
    repeat (45) @(negedge clk);
    check_tx_line("t1_line", base, 1, 8'hA5);
    bus_read(2'd1, rd);
    check("t1_status_idle", 64'(rd), 64'h10008);

    // 2: 18 back-to-back writes: first goes straight to the wire, 16 fill the FIFO, 1 dropped
    do_reset();
    bus_write(2'd2, 32'd4);
    @(negedge clk);
    base = cyc + 2;
    for (int i = 0; i < 18; i++) begin
      address = 2'd0;
      writedata = 32'h10 + 32'(i);
      writeenable = 1'b1;
      @(negedge clk);
    end
    writeenable = 1'b0;
    bus_read(2'd1, rd);
    check("t2_status_ovf", 64'(rd), 64'h94);
    bus_read(2'd1, rd);
    check("t2_status_cleared", 64'(rd), 64'h14);
    repeat (700) @(negedge clk);
    check_tx_line("t2_line", base, 17, 8'h10);
    bus_read(2'd1, rd);
    check("t2_status_done", 64'(rd), 64'h10008);

    // 3: receive 0x3C at DIV=8
    do_reset();
    bus_write(2'd2, 32'd8);
    send_rx(8'h3C, 8, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(2'd1, rd);
    check("t3_status", 64'(rd), 64'h10009);
    bus_read(2'd0, rd);
    check("t3_data", 64'(rd), 64'h13C);
    bus_read(2'd0, rd);
    check("t3_data_empty", 64'(rd), 64'h0);

    // 4: 17 frames without reads -> full + overrun, first 16 kept in order
    do_reset();
    bus_write(2'd2, 32'd8);
    for (int i = 0; i < 17; i++) send_rx(8'hC0 + 8'(i), 8, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(2'd1, rd);
    check("t4_status_full", 64'(rd), 64'h1002B);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, rd);
      check($sformatf("t4_data%0d", i), 64'(rd), 64'h100 | 64'(8'hC0 + 8'(i)));
    end
    bus_read(2'd0, rd);
    check("t4_data_empty", 64'(rd), 64'h0);
    bus_read(2'd1, rd);
    check("t4_status_after", 64'(rd), 64'h10008);

    // 5: bad stop bit, then a one-clock glitch
    do_reset();
    bus_write(2'd2, 32'd8);
    send_rx(8'h55, 8, 1'b0);
    repeat (6) @(negedge clk);
    bus_read(2'd1, rd);
    check("t5_status_ferr", 64'(rd), 64'h10048);
    bus_read(2'd1, rd);
    check("t5_status_cleared", 64'(rd), 64'h10008);
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(2'd1, rd);
    check("t5_glitch_status", 64'(rd), 64'h10008);
    bus_read(2'd0, rd);
    check("t5_glitch_data", 64'(rd), 64'h0);

    // 6: divisor clamp, reserved address, reset mid-frame
    do_reset();
    bus_write(2'd2, 32'd2);
    bus_read(2'd2, rd);
    check("t6_div_clamp", 64'(rd), 64'd4);
    bus_write(2'd2, 32'd1000);
    bus_read(2'd2, rd);
    check("t6_div_1000", 64'(rd), 64'd1000);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    check("t6_reserved", 64'(rd), 64'h0);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h00);
    repeat (10) @(negedge clk);
    check("t6_midframe_low", 64'(serial_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_line_high", 64'(serial_out), 64'd1);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_line_stays_high", 64'(serial_out), 64'd1);
    bus_read(2'd1, rd);
    check("t6_status_empty", 64'(rd), 64'h10008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
